reg_4bit_siso: RTL and testbench
================================

# reg_4bit_siso

Serial-in, serial-out shift register: a 1-bit stream entering on `A` leaves on `Y` delayed by DEPTH clock cycles (default 4). It is a leaf datapath block used wherever a fixed-cycle delay line or bit-serial pipeline stage is needed. It has no handshake: every rising clock edge shifts the chain unless reset is asserted.

## Interface
Parameters:
- DEPTH, 4, number of stages (≥1); sets input-to-output latency.
- RESET_VAL, 1'b0, value loaded into every stage on reset.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- clr  input  1  reset; one clock; reset is synchronous and active-low.
- A  input  1  serial data in, sampled on each rising edge of clk.
- Y  output  1  serial data out; the registered last stage.

## Operation
- State: stage[0..DEPTH-1], one flop per stage. `Y` = stage[DEPTH-1], with no combinational path from `A`.
- On a rising edge with clr=0:
  - every stage loads RESET_VAL;
  - `A` is ignored, including X or Z values.
- On a rising edge with clr=1:
  - stage[0] ← A;
  - stage[i] ← stage[i-1] for i = 1..DEPTH-1, all simultaneously (nonblocking semantics).
- Reset dominates shifting. If clr=0 and A changes on the same edge, the result is still all RESET_VAL.
- Reset mid-stream: all in-flight bits are discarded. `Y` = RESET_VAL from that edge until DEPTH shifting edges after clr returns high.
- No enable, no parallel load or read, no wrap-around: the bit shifted out of stage[DEPTH-1] is lost.
- Before the first reset edge, the output is undefined. Simulation may show X; no power-on value is required.

## Timing
- Latency: the `A` value sampled at edge k appears on `Y` immediately after edge k+DEPTH-1 (4th sampling edge for DEPTH=4). It is stable for one full cycle.
- Reset value of `Y`: RESET_VAL (0), valid right after the first edge with clr=0.
- Deassertion of clr is sampled at the next rising edge; the first shift happens on the first edge that sees clr=1.
- `A` and `clr` must meet setup/hold to the rising clk edge. Changes between edges have no effect.
- Throughput: one bit per cycle, continuous.

## Structure
- Shared package `reg_siso_pkg`:
  - constant DEFAULT_DEPTH = 4;
  - constant DEFAULT_RESET_VAL = 1'b0.
- Natural sub-module: `dff_sync_rstn`, a 1-bit D flop with synchronous active-low reset to a parameter value. The top instantiates DEPTH copies in a generate loop, chained output to input.
- Parameter check: elaborate-time error if DEPTH < 1.

## Test plan
- Reset: clk period 10, clr=0 over one rising edge with A=X → `Y`=0 after that edge, and all stages 0.
- Latency: after reset, A=1 for exactly one edge (clr=1), then 0 → `Y`=1 for exactly one cycle, following the 4th shifting edge after A was sampled. `Y`=0 otherwise.
- Pattern: A changes 2 ns after each rising edge, repeating 0,0,1,1 for 16 cycles → `Y` reproduces 0,0,1,1… delayed by 4 edges. First `Y`=1 appears 30 time units after the edge that sampled the first 1.
- Mid-stream reset: fill with 1,1,1,1, then clr=0 for one edge → `Y`=0 immediately. `Y` stays 0 for the next 4 edges with A=0 and clr=1.
- Reset priority: clr=0 held for 3 edges while A=1 → `Y` remains 0 throughout. After clr=1 with A=1, `Y` goes to 1 after the 4th edge.
- Parameter sweep: DEPTH=1 → `Y` follows A with a 1-edge delay. DEPTH=8 → a single-cycle pulse on A emerges on `Y` 8 edges later.

Source files
------------

// File: rtl/reg_siso_pkg.sv
// Shared defaults for the serial-in/serial-out delay line.
package reg_siso_pkg;

  localparam int unsigned DEFAULT_DEPTH     = 4;
  localparam logic        DEFAULT_RESET_VAL = 1'b0;

endpackage

// File: rtl/dff_sync_rstn.sv
// Single-bit D flop with synchronous active-low reset to a parameterised value.
module dff_sync_rstn #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic q_d, q_q;

  // Reset wins over data so an X on d_i cannot leak into a cleared stage.
  always_comb begin
    q_d = d_i;
    if (!rst_ni) begin
      q_d = ResetVal;
    end
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_4bit_siso.sv
// Serial-in, serial-out shift register: A reaches Y after DEPTH rising edges.
module reg_4bit_siso
  import reg_siso_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter logic        RESET_VAL = DEFAULT_RESET_VAL
) (
  input  logic clk,
  input  logic clr,
  input  logic A,
  output logic Y
);

  if (DEPTH < 1) begin : g_depth_check
    $error("reg_4bit_siso: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] stage;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic d;
    if (i == 0) begin : g_head
      assign d = A;
    end else begin : g_link
      assign d = stage[i-1];
    end

    dff_sync_rstn #(
      .ResetVal (RESET_VAL)
    ) u_dff (
      .clk_i  (clk),
      .rst_ni (clr),
      .d_i    (d),
      .q_o    (stage[i])
    );
  end

  assign Y = stage[DEPTH-1];

endmodule

// File: tb/tb_reg_4bit_siso.sv
// Directed bench for reg_4bit_siso at DEPTH 4, 1 and 8 sharing one stimulus.
module tb_reg_4bit_siso;

  logic clk = 1'b0;
  logic clr;
  logic A;
  logic y4, y1, y8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_4bit_siso u_dut4 (
    .clk (clk),
    .clr (clr),
    .A   (A),
    .Y   (y4)
  );

  reg_4bit_siso #(
    .DEPTH (1)
  ) u_dut1 (
    .clk (clk),
    .clr (clr),
    .A   (A),
    .Y   (y1)
  );

  reg_4bit_siso #(
    .DEPTH (8)
  ) u_dut8 (
    .clk (clk),
    .clr (clr),
    .A   (A),
    .Y   (y8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs, then sample 1 ns after the next rising edge.
  task automatic tick(input logic a, input logic c);
    A   = a;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pat;
  time        t_samp, t_rise;
  logic       seen_rise;

  initial begin
    pat = 4'b1100; // pat[j] for j=0..3 is 0,0,1,1
    A   = 1'b0;
    clr = 1'b1;
    @(negedge clk);

    // Reset with A unknown.
    tick(1'bx, 1'b0);
    check("rst_y4", {31'd0, y4}, 32'd0);
    check("rst_y1", {31'd0, y1}, 32'd0);
    check("rst_y8", {31'd0, y8}, 32'd0);

    // Single-cycle pulse: sampled at j=0.
    for (int j = 0; j < 10; j++) begin
      tick((j == 0) ? 1'b1 : 1'b0, 1'b1);
      check($sformatf("lat_y4_%0d", j), {31'd0, y4}, {31'd0, (j == 3)});
      check($sformatf("lat_y1_%0d", j), {31'd0, y1}, {31'd0, (j == 0)});
      check($sformatf("lat_y8_%0d", j), {31'd0, y8}, {31'd0, (j == 7)});
    end

    // Repeating 0,0,1,1 pattern over 16 edges; all pipes start at zero.
    seen_rise = 1'b0;
    t_samp    = 0;
    t_rise    = 0;
    for (int j = 0; j < 16; j++) begin
      logic e4, e1, e8;
      e4 = (j >= 3) ? pat[(j - 3) % 4] : 1'b0;
      e1 = pat[j % 4];
      e8 = (j >= 7) ? pat[(j - 7) % 4] : 1'b0;
      tick(pat[j % 4], 1'b1);
      if (j == 2) t_samp = $time;
      if (y4 === 1'b1 && !seen_rise) begin
        seen_rise = 1'b1;
        t_rise    = $time;
      end
      check($sformatf("pat_y4_%0d", j), {31'd0, y4}, {31'd0, e4});
      check($sformatf("pat_y1_%0d", j), {31'd0, y1}, {31'd0, e1});
      check($sformatf("pat_y8_%0d", j), {31'd0, y8}, {31'd0, e8});
    end
    check("pat_first_rise_delay", 32'(t_rise - t_samp), 32'd30);

    // Mid-stream reset after filling with ones.
    for (int j = 0; j < 4; j++) tick(1'b1, 1'b1);
    check("fill_y4", {31'd0, y4}, 32'd1);
    tick(1'b1, 1'b0);
    check("mid_rst_y4", {31'd0, y4}, 32'd0);
    check("mid_rst_y1", {31'd0, y1}, 32'd0);
    check("mid_rst_y8", {31'd0, y8}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, 1'b1);
      check($sformatf("post_rst_y4_%0d", j), {31'd0, y4}, 32'd0);
    end

    // Reset held with A=1, then release with A=1.
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 1'b0);
      check($sformatf("prio_y4_%0d", j), {31'd0, y4}, 32'd0);
      check($sformatf("prio_y1_%0d", j), {31'd0, y1}, 32'd0);
    end
    for (int j = 0; j < 4; j++) begin
      tick(1'b1, 1'b1);
      check($sformatf("rel_y4_%0d", j), {31'd0, y4}, {31'd0, (j == 3)});
      check($sformatf("rel_y1_%0d", j), {31'd0, y1}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
